// File: rtl/regfile_2w2r_param.sv
// Dual-write, dual-read register file with a per-register pending scoreboard
// and a saturating same-address write-conflict counter. Optional macro: REGFILE_BYPASS_EN.
module regfile_2w2r_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic [ADDR_WIDTH-1:0] WriteReg1,
    input  logic [ADDR_WIDTH-1:0] WriteReg2,
    input  logic [DATA_WIDTH-1:0] WriteData1,
    input  logic [DATA_WIDTH-1:0] WriteData2,
    input  logic [1:0]            RegWrite_signal,
    input  logic                  Reserve_en,
    input  logic [ADDR_WIDTH-1:0] ReserveReg,
    output logic                  Pending1,
    output logic                  Pending2,
    output logic [CNT_WIDTH-1:0]  ConflictCount
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pend;
    logic [DEPTH-1:0]      pendNext;
    logic [CNT_WIDTH-1:0]  conflictCnt;

    logic write1Hit;
    logic write2Hit;
    logic dualConflict;
    logic reserveHit;

    logic [DATA_WIDTH-1:0] rdData1;
    logic [DATA_WIDTH-1:0] rdData2;
    logic                  rdPend1;
    logic                  rdPend2;

    // Register 0 is hard-wired, so every qualifier excludes it up front.
    always_comb begin
        write1Hit    = RegWrite_signal[1] && (WriteReg1 != '0);
        write2Hit    = RegWrite_signal[0] && (WriteReg2 != '0);
        dualConflict = write1Hit && write2Hit && (WriteReg1 == WriteReg2);
        reserveHit   = Reserve_en && (ReserveReg != '0);
    end

    // Port 2 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (write1Hit) begin
                regs[WriteReg1] <= WriteData1;
            end
            if (write2Hit) begin
                regs[WriteReg2] <= WriteData2;
            end
        end
    end

    // Writes retire producers; a reserve in the same cycle is a newer producer and wins.
    always_comb begin
        pendNext = pend;
        if (write1Hit) begin
            pendNext[WriteReg1] = 1'b0;
        end
        if (write2Hit) begin
            pendNext[WriteReg2] = 1'b0;
        end
        if (reserveHit) begin
            pendNext[ReserveReg] = 1'b1;
        end
        pendNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pendNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflictCnt <= '0;
        end else if (dualConflict && (conflictCnt != '1)) begin
            conflictCnt <= conflictCnt + 1'b1;
        end
    end

    always_comb begin
        rdData1 = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
        rdPend1 = pend[ReadReg1];
`ifdef REGFILE_BYPASS_EN
        // Forward in-flight write data; port 2 takes priority on a dual match.
        if (ReadReg1 != '0) begin
            if (write2Hit && (WriteReg2 == ReadReg1)) begin
                rdData1 = WriteData2;
                rdPend1 = reserveHit && (ReserveReg == ReadReg1);
            end else if (write1Hit && (WriteReg1 == ReadReg1)) begin
                rdData1 = WriteData1;
                rdPend1 = reserveHit && (ReserveReg == ReadReg1);
            end
        end
`endif
    end

    always_comb begin
        rdData2 = (ReadReg2 == '0) ? '0 : regs[ReadReg2];
        rdPend2 = pend[ReadReg2];
`ifdef REGFILE_BYPASS_EN
        if (ReadReg2 != '0) begin
            if (write2Hit && (WriteReg2 == ReadReg2)) begin
                rdData2 = WriteData2;
                rdPend2 = reserveHit && (ReserveReg == ReadReg2);
            end else if (write1Hit && (WriteReg1 == ReadReg2)) begin
                rdData2 = WriteData1;
                rdPend2 = reserveHit && (ReserveReg == ReadReg2);
            end
        end
`endif
    end

    // Outputs are held at zero while reset is asserted, before the clearing edge lands.
    always_comb begin
        ReadData1     = reset ? '0 : rdData1;
        ReadData2     = reset ? '0 : rdData2;
        Pending1      = reset ? 1'b0 : rdPend1;
        Pending2      = reset ? 1'b0 : rdPend2;
        ConflictCount = reset ? '0 : conflictCnt;
    end

endmodule

// File: tb/tb_regfile_2w2r_param.sv
// Testbench for regfile_2w2r_param: table-driven vectors through a scoreboard queue,
// plus hand-written same-cycle read and counter saturation sequences.
module tb_regfile_2w2r_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ReadReg1, ReadReg2, WriteReg1, WriteReg2, ReserveReg;
    logic [31:0] ReadData1, ReadData2, WriteData1, WriteData2;
    logic [1:0]  RegWrite_signal;
    logic        Reserve_en, Pending1, Pending2;
    logic [7:0]  ConflictCount;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  wa2;
        logic [31:0] wd2;
        logic        resEn;
        logic [4:0]  resReg;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] expD1;
        logic [31:0] expD2;
        logic        expP1;
        logic        expP2;
        logic [7:0]  expCnt;
    } vec_t;

    vec_t vecs[14];
    vec_t expQ[$];

    regfile_2w2r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .WriteReg1(WriteReg1), .WriteReg2(WriteReg2),
        .WriteData1(WriteData1), .WriteData2(WriteData2),
        .RegWrite_signal(RegWrite_signal),
        .Reserve_en(Reserve_en), .ReserveReg(ReserveReg),
        .Pending1(Pending1), .Pending2(Pending2),
        .ConflictCount(ConflictCount)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [1:0] we,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic [4:0] wa2, input logic [31:0] wd2,
                                input logic resEn, input logic [4:0] resReg,
                                input logic [4:0] ra1, input logic [4:0] ra2,
                                input logic [31:0] expD1, input logic [31:0] expD2,
                                input logic expP1, input logic expP2,
                                input logic [7:0] expCnt);
        vec_t v;
        v.rst = rst; v.we = we; v.wa1 = wa1; v.wd1 = wd1; v.wa2 = wa2; v.wd2 = wd2;
        v.resEn = resEn; v.resReg = resReg; v.ra1 = ra1; v.ra2 = ra2;
        v.expD1 = expD1; v.expD2 = expD2; v.expP1 = expP1; v.expP2 = expP2;
        v.expCnt = expCnt;
        return v;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        reset = 1'b0; RegWrite_signal = 2'b00; Reserve_en = 1'b0;
        WriteReg1 = '0; WriteReg2 = '0; WriteData1 = '0; WriteData2 = '0; ReserveReg = '0;
    endtask

    task automatic driveInputs(input vec_t v);
        reset = v.rst; RegWrite_signal = v.we;
        WriteReg1 = v.wa1; WriteData1 = v.wd1; WriteReg2 = v.wa2; WriteData2 = v.wd2;
        Reserve_en = v.resEn; ReserveReg = v.resReg;
        ReadReg1 = v.ra1; ReadReg2 = v.ra2;
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        if (expQ.size() == 0) begin
            compare({tag, " queue empty"}, 32'd1, 32'd0);
            return;
        end
        e = expQ.pop_front();
        compare({tag, " ReadData1"}, ReadData1, e.expD1);
        compare({tag, " ReadData2"}, ReadData2, e.expD2);
        compare({tag, " Pending1"}, {31'd0, Pending1}, {31'd0, e.expP1});
        compare({tag, " Pending2"}, {31'd0, Pending2}, {31'd0, e.expP2});
        compare({tag, " ConflictCount"}, {24'd0, ConflictCount}, {24'd0, e.expCnt});
    endtask

    // Drive one cycle of stimulus, let the edge commit it, then check with inputs idle.
    task automatic applyStimulus(input vec_t v, input string tag);
        driveInputs(v);
        expQ.push_back(v);
        @(posedge clk);
        #1;
        idleInputs();
        #1;
        checkOutput(tag);
    endtask

    task automatic conflictCycles(input int n);
        for (int i = 0; i < n; i++) begin
            reset = 1'b0; RegWrite_signal = 2'b11;
            WriteReg1 = 5'd9; WriteData1 = i; WriteReg2 = 5'd9; WriteData2 = ~i;
            @(posedge clk);
            #1;
        end
        idleInputs();
        #1;
    endtask

    initial begin
        idleInputs();
        ReadReg1 = '0; ReadReg2 = '0;

        //           rst we     wa1    wd1           wa2    wd2           rE  rR     ra1    ra2    expD1         expD2         P1 P2 cnt
        vecs[0]  = mk(1, 2'b11, 5'd3,  32'h1111,     5'd3,  32'h2222,     1, 5'd4,  5'd3,  5'd4,  32'h0,        32'h0,        0, 0, 8'd0);
        vecs[1]  = mk(0, 2'b10, 5'd10, 32'd14,       5'd0,  32'h0,        0, 5'd0,  5'd10, 5'd0,  32'd14,       32'h0,        0, 0, 8'd0);
        vecs[2]  = mk(0, 2'b11, 5'd11, 32'd5,        5'd11, 32'd9,        0, 5'd0,  5'd11, 5'd10, 32'd9,        32'd14,       0, 0, 8'd1);
        vecs[3]  = mk(0, 2'b01, 5'd0,  32'h0,        5'd12, 32'hA5A5A5A5, 0, 5'd0,  5'd12, 5'd11, 32'hA5A5A5A5, 32'd9,        0, 0, 8'd1);
        vecs[4]  = mk(0, 2'b11, 5'd13, 32'h1234,     5'd14, 32'h5678,     0, 5'd0,  5'd13, 5'd14, 32'h1234,     32'h5678,     0, 0, 8'd1);
        vecs[5]  = mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1, 5'd7,  5'd7,  5'd7,  32'h0,        32'h0,        1, 1, 8'd1);
        vecs[6]  = mk(0, 2'b10, 5'd7,  32'h77,       5'd0,  32'h0,        0, 5'd0,  5'd7,  5'd10, 32'h77,       32'd14,       0, 0, 8'd1);
        vecs[7]  = mk(0, 2'b01, 5'd0,  32'h0,        5'd7,  32'h88,       1, 5'd7,  5'd7,  5'd12, 32'h88,       32'hA5A5A5A5, 1, 0, 8'd1);
        vecs[8]  = mk(0, 2'b11, 5'd0,  32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  5'd0,  5'd7,  32'h0,        32'h88,       0, 1, 8'd1);
        vecs[9]  = mk(0, 2'b00, 5'd10, 32'hDEAD,     5'd7,  32'hBEEF,     0, 5'd0,  5'd10, 5'd7,  32'd14,       32'h88,       0, 1, 8'd1);
        vecs[10] = mk(0, 2'b11, 5'd20, 32'd1,        5'd21, 32'd2,        1, 5'd20, 5'd20, 5'd21, 32'd1,        32'd2,        1, 0, 8'd1);
        vecs[11] = mk(0, 2'b11, 5'd7,  32'h99,       5'd3,  32'h33,       1, 5'd4,  5'd7,  5'd4,  32'h99,       32'h0,        0, 1, 8'd1);
        vecs[12] = mk(1, 2'b11, 5'd3,  32'h55,       5'd3,  32'h66,       1, 5'd4,  5'd3,  5'd4,  32'h0,        32'h0,        0, 0, 8'd0);
        vecs[13] = mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        0, 5'd0,  5'd20, 5'd7,  32'h0,        32'h0,        0, 0, 8'd0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Every address reads back zero and idle after the reset in vec12.
        for (int a = 0; a < 32; a += 2) begin
            ReadReg1 = a[4:0]; ReadReg2 = a[4:0] + 5'd1;
            #1;
            compare($sformatf("postReset rd%0d", a), ReadData1 | ReadData2, 32'h0);
            compare($sformatf("postReset pend%0d", a), {30'd0, Pending1, Pending2}, 32'h0);
        end

        // Same-cycle read of a reserved register while it is being written.
        applyStimulus(mk(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, 5'd10,
                         5'd10, 5'd10, 32'h0, 32'h0, 1, 1, 8'd0), "reserve10");
        driveInputs(mk(0, 2'b10, 5'd10, 32'd14, 5'd0, 32'h0, 0, 5'd0,
                       5'd10, 5'd5, 32'h0, 32'h0, 0, 0, 8'd0));
        #1;
        compare("sameCycle ReadData1", ReadData1, BYP ? 32'd14 : 32'd0);
        compare("sameCycle Pending1", {31'd0, Pending1}, BYP ? 32'd0 : 32'd1);
        @(posedge clk);
        #1;
        idleInputs();
        #1;
        compare("afterWrite ReadData1", ReadData1, 32'd14);
        compare("afterWrite Pending1", {31'd0, Pending1}, 32'd0);

        // Dual same-address write with reserve of that register, read in the same cycle.
        driveInputs(mk(0, 2'b11, 5'd15, 32'd1, 5'd15, 32'd2, 1, 5'd15,
                       5'd15, 5'd0, 32'h0, 32'h0, 0, 0, 8'd0));
        #1;
        compare("dualSame ReadData1", ReadData1, BYP ? 32'd2 : 32'd0);
        compare("dualSame Pending1", {31'd0, Pending1}, 32'd0 | BYP);
        @(posedge clk);
        #1;
        idleInputs();
        #1;
        compare("dualAfter ReadData1", ReadData1, 32'd2);
        compare("dualAfter Pending1", {31'd0, Pending1}, 32'd1);
        compare("dualAfter ConflictCount", {24'd0, ConflictCount}, 32'd1);

        // Counter saturation from a clean start.
        applyStimulus(mk(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0,
                         5'd15, 5'd10, 32'h0, 32'h0, 0, 0, 8'd0), "satReset");
        conflictCycles(254);
        compare("sat ConflictCount@254", {24'd0, ConflictCount}, 32'd254);
        conflictCycles(1);
        compare("sat ConflictCount@255", {24'd0, ConflictCount}, 32'd255);
        conflictCycles(46);
        compare("sat ConflictCount@301", {24'd0, ConflictCount}, 32'd255);
        ReadReg1 = 5'd9;
        #1;
        compare("sat reg9 port2 data", ReadData1, ~32'd45);

        if (expQ.size() != 0) begin
            compare("scoreboard drained", expQ.size(), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/regfile_2w2r_param.md
# regfile_2w2r_param

Parameterised dual-write, dual-read register file with a per-register pending scoreboard and a write-conflict counter. It is the next generation of the processor's register memory: width and depth are now configurable, simultaneous same-address writes resolve deterministically, and there is an optional same-cycle write-to-read bypass. It sits in the decode/writeback path of the MIPS datapath. Issue logic uses the pending bits to stall on read-after-write hazards.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- CNT_WIDTH, 8, conflict counter width

Ports:
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- ReadReg1, ReadReg2  in  ADDR_WIDTH  read addresses
- ReadData1, ReadData2  out  DATA_WIDTH  read data
- WriteReg1, WriteReg2  in  ADDR_WIDTH  write addresses
- WriteData1, WriteData2  in  DATA_WIDTH  write data
- RegWrite_signal  in  2  bit1 enables write port 1, bit0 enables write port 2
- Reserve_en  in  1  mark ReserveReg pending
- ReserveReg  in  ADDR_WIDTH  register being reserved by a newly issued producer
- Pending1, Pending2  out  1  pending bit of ReadReg1 / ReadReg2
- ConflictCount  out  CNT_WIDTH  saturating count of same-address dual-write cycles

## Operation
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits. Register 0 always reads 0. Writes to it are discarded and it is never pending.
- Reads are combinational from stored state: ReadDataN = reg[ReadRegN], and PendingN = pend[ReadRegN].
- Writes:
  - Port 1 writes when RegWrite_signal[1] is set; port 2 writes when RegWrite_signal[0] is set. Both ports may write in one cycle.
  - If both are enabled and WriteReg1 == WriteReg2 != 0, port 2 wins (WriteData2 stored).
  - Each such conflict cycle increments ConflictCount. The counter saturates at all-ones and never wraps.
- Scoreboard:
  - Reserve_en with ReserveReg != 0 sets pend[ReserveReg].
  - A committed write to register r clears pend[r].
  - Reserve and write to the same register in the same cycle: the reserve wins and pend stays 1, because a new producer has been issued.
  - Reserve of register 0 is ignored.
- Reset:
  - Clears every register, every pend bit, and ConflictCount.
  - Reset has priority over same-cycle writes and reserves.
  - Reset asserted mid-operation discards all in-flight state at that edge.
- Output values during and after reset: ReadData1/2 = 0, Pending1/2 = 0, ConflictCount = 0.

## Timing
- Write latency is 1 cycle. Data presented with enable before edge k is readable combinationally after edge k.
- Read latency is 0 cycles (combinational) with respect to ReadReg changes.
- A pend bit set at edge k is visible on PendingN after edge k; a clear follows the same rule.
- ConflictCount updates at the edge that ends the conflict cycle.
- Without bypass, a read of a register being written in the same cycle returns the old value.

## Configuration
- Macro REGFILE_BYPASS_EN.
- When defined, a same-cycle bypass applies:
  - If ReadRegN != 0 matches an enabled write address, ReadDataN returns that WriteData combinationally. On a dual match, port 2's data is returned.
  - PendingN is forced to 0 for that cycle unless the same register is also being reserved this cycle.
- When undefined, there is no forwarding; reads reflect stored state only.
- Storage, scoreboard and counter behaviour are identical in both builds.

## Test plan
- Reset, then read all addresses -> every ReadData = 0, Pending = 0, ConflictCount = 0.
- Write 14 to reg 10 via port 1 (RegWrite_signal=2'b10) -> ReadReg1=10 gives 14 after the edge. Same-cycle read gives 0, or 14 with REGFILE_BYPASS_EN.
- Port 1 writes 5 and port 2 writes 9, both to reg 11 (2'b11) -> reg 11 = 9 and ConflictCount = 1. After 300 more conflict cycles with CNT_WIDTH=8, ConflictCount = 255.
- Reserve reg 7 -> Pending1 = 1 for ReadReg1=7. Write reg 7 the next cycle -> Pending1 = 0. Reserve and write reg 7 in the same cycle -> Pending1 stays 1.
- Write 0xFFFF_FFFF to reg 0 and reserve reg 0 -> reads return 0, Pending = 0.
- Assert reset in the same cycle as writes to reg 3 and a reserve of reg 4 -> reg 3 = 0, reg 4 not pending, counter = 0.
